// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio mixer/scheduler: FSM encoding,
// unity gain, accumulator sizing and saturation limits.
package audio_mix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_MAC     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_e;

  localparam int unsigned GAIN_W_DEF = 6;
  localparam int unsigned UNITY_GAIN = 2 ** (GAIN_W_DEF - 2);

  // Wide enough to sum NUM_SRC full-scale products with no overflow.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned gain_w,
                                            input int unsigned num_src);
    return in_w + gain_w + $clog2(num_src) + 1;
  endfunction

  function automatic longint sat_hi(input int unsigned out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int unsigned out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/audio_mix_sat.sv
// Combinational signed clamp from accumulator width down to OUT_W, with a
// flag raised whenever the value had to be clamped.
module audio_mix_sat
  import audio_mix_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 24
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] sat_o_c,
  output logic                    clip_o_c
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(OUT_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(OUT_W));

  always_comb begin
    sat_o_c  = OUT_W'(acc_i);
    clip_o_c = 1'b0;
    if (acc_i > HI) begin
      sat_o_c  = OUT_W'(HI);
      clip_o_c = 1'b1;
    end else if (acc_i < LO) begin
      sat_o_c  = OUT_W'(LO);
      clip_o_c = 1'b1;
    end
  end

endmodule

// File: rtl/audio_mix_sched.sv
// Time-multiplexed stereo mixer: captures all sources on a strobe, runs them
// through one shared gain multiplier, accumulates per side and saturates.
// Optional sticky clip flags are built when AUDIO_MIX_CLIP_DETECT_EN is defined.
module audio_mix_sched
  import audio_mix_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IN_W    = 23,
  parameter int unsigned OUT_W   = 24,
  parameter int unsigned GAIN_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      next_sample,
  input  logic [NUM_SRC*IN_W-1:0]   src_data,
  input  logic [NUM_SRC*GAIN_W-1:0] src_gain,
  input  logic [NUM_SRC-1:0]        src_right,
  input  logic                      overrun_clr,
  output logic [OUT_W-1:0]          out_left,
  output logic [OUT_W-1:0]          out_right,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic                      clip_left,
  output logic                      clip_right
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned MUL_W = IN_W + GAIN_W + 1;
  localparam int unsigned ACC_W = acc_width(IN_W, GAIN_W, NUM_SRC);
  localparam int unsigned SHIFT = GAIN_W - 2;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [IN_W-1:0]    data_q [NUM_SRC];
  logic signed [IN_W-1:0]    data_d [NUM_SRC];
  logic [GAIN_W-1:0]         gain_q [NUM_SRC];
  logic [GAIN_W-1:0]         gain_d [NUM_SRC];
  logic [NUM_SRC-1:0]        right_q, right_d;
  logic signed [MUL_W-1:0]   prod_q, prod_d;
  logic                      prod_right_q, prod_right_d;
  logic                      prod_vld_q, prod_vld_d;
  logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]          out_left_q, out_left_d, out_right_q, out_right_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

  logic signed [IN_W-1:0]    cur_data_c;
  logic signed [GAIN_W:0]    gain_ext_c;
  logic signed [MUL_W-1:0]   mul_c;
  logic signed [OUT_W-1:0]   sat_l_c, sat_r_c;
  logic                      clip_l_c, clip_r_c;

  // Shared multiplier operand select; gain is zero-extended so it stays positive.
  always_comb begin
    cur_data_c = data_q[idx_q];
    gain_ext_c = {1'b0, gain_q[idx_q]};
    mul_c      = MUL_W'(cur_data_c) * MUL_W'(gain_ext_c);
  end

  audio_mix_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
    .acc_i    (acc_l_q),
    .sat_o_c  (sat_l_c),
    .clip_o_c (clip_l_c)
  );

  audio_mix_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
    .acc_i    (acc_r_q),
    .sat_o_c  (sat_r_c),
    .clip_o_c (clip_r_c)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    gain_d       = gain_q;
    right_d      = right_q;
    prod_d       = prod_q;
    prod_right_d = prod_right_q;
    prod_vld_d   = 1'b0;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    out_left_d   = out_left_q;
    out_right_d  = out_right_q;
    out_valid_d  = 1'b0;

    // The product registered in the previous cycle lands in its side's accumulator.
    if (prod_vld_q) begin
      if (prod_right_q) acc_r_d = acc_r_q + ACC_W'(prod_q);
      else              acc_l_d = acc_l_q + ACC_W'(prod_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (next_sample) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          data_d[i] = src_data[i*IN_W +: IN_W];
          gain_d[i] = src_gain[i*GAIN_W +: GAIN_W];
        end
        right_d = src_right;
        acc_l_d = '0;
        acc_r_d = '0;
        idx_d   = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        prod_d       = mul_c >>> SHIFT;
        prod_right_d = right_q[idx_q];
        prod_vld_d   = 1'b1;
        if (idx_q == IDX_W'(NUM_SRC - 1)) state_d = ST_DRAIN;
        else                              idx_d   = idx_q + IDX_W'(1);
      end
      ST_DRAIN: begin
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        out_left_d  = sat_l_c;
        out_right_d = sat_r_c;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    // Strobe during any busy state is dropped; a new overrun beats a clear.
    if (next_sample && (state_q != ST_IDLE)) overrun_d = 1'b1;
    else if (overrun_clr)                    overrun_d = 1'b0;
    else                                     overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= '0;
        gain_q[i] <= '0;
      end
      right_q      <= '0;
      prod_q       <= '0;
      prod_right_q <= 1'b0;
      prod_vld_q   <= 1'b0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      out_left_q   <= '0;
      out_right_q  <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      gain_q       <= gain_d;
      right_q      <= right_d;
      prod_q       <= prod_d;
      prod_right_q <= prod_right_d;
      prod_vld_q   <= prod_vld_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      out_left_q   <= out_left_d;
      out_right_q  <= out_right_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

`ifdef AUDIO_MIX_CLIP_DETECT_EN
  logic clip_l_q, clip_l_d, clip_r_q, clip_r_d;

  // Sticky clip flags share the overrun clear; a same-cycle set wins.
  always_comb begin
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    if (overrun_clr) begin
      clip_l_d = 1'b0;
      clip_r_d = 1'b0;
    end
    if (state_q == ST_OUTPUT) begin
      if (clip_l_c) clip_l_d = 1'b1;
      if (clip_r_c) clip_r_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
    end else begin
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
    end
  end

  assign clip_left  = clip_l_q;
  assign clip_right = clip_r_q;
`else
  logic clip_unused_c;
  assign clip_unused_c = clip_l_c ^ clip_r_c;
  assign clip_left     = 1'b0;
  assign clip_right    = 1'b0;
`endif

endmodule

// File: tb/tb_audio_mix_sched.sv
// Scoreboard bench for audio_mix_sched: stimulus pushes expected stereo
// results, a negedge monitor pops and checks them along with the latency.
module tb_audio_mix_sched;
  import audio_mix_pkg::*;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned IN_W    = 23;
  localparam int unsigned OUT_W   = 24;
  localparam int unsigned GAIN_W  = 6;
  localparam int          LAT     = NUM_SRC + 3;
`ifdef AUDIO_MIX_CLIP_DETECT_EN
  localparam longint CLIP_EN = 1;
`else
  localparam longint CLIP_EN = 0;
`endif

  typedef struct {
    longint l;
    longint r;
    int     cyc;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      next_sample = 1'b0;
  logic [NUM_SRC*IN_W-1:0]   src_data = '0;
  logic [NUM_SRC*GAIN_W-1:0] src_gain = '0;
  logic [NUM_SRC-1:0]        src_right = '0;
  logic                      overrun_clr = 1'b0;
  logic [OUT_W-1:0]          out_left, out_right;
  logic                      out_valid, busy, overrun, clip_left, clip_right;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  audio_mix_sched #(
    .NUM_SRC(NUM_SRC), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .next_sample (next_sample),
    .src_data    (src_data),
    .src_gain    (src_gain),
    .src_right   (src_right),
    .overrun_clr (overrun_clr),
    .out_left    (out_left),
    .out_right   (out_right),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .clip_left   (clip_left),
    .clip_right  (clip_right)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got out_valid=1, expected no pending pass (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_left", longint'($signed(out_left)), e.l);
        chk("out_right", longint'($signed(out_right)), e.r);
        chk("latency_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  task automatic set_src(input int d0, input int d1, input int d2, input int d3,
                         input int g0, input int g1, input int g2, input int g3,
                         input logic [NUM_SRC-1:0] rt);
    src_data  = {IN_W'(d3), IN_W'(d2), IN_W'(d1), IN_W'(d0)};
    src_gain  = {GAIN_W'(g3), GAIN_W'(g2), GAIN_W'(g1), GAIN_W'(g0)};
    src_right = rt;
  endtask

  // One-cycle strobe; returns at the negedge after the sampling edge.
  task automatic strobe(input bit push, input longint l, input longint r);
    @(negedge clk);
    next_sample = 1'b1;
    if (push) sb.push_back('{l: l, r: r, cyc: cyc + 1 + LAT});
    @(negedge clk);
    next_sample = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_left"},    longint'(out_left),   0);
    chk({tag, "_right"},   longint'(out_right),  0);
    chk({tag, "_valid"},   longint'(out_valid),  0);
    chk({tag, "_busy"},    longint'(busy),       0);
    chk({tag, "_overrun"}, longint'(overrun),    0);
    chk({tag, "_clip_l"},  longint'(clip_left),  0);
    chk({tag, "_clip_r"},  longint'(clip_right), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run by 200000");
    $fatal(1);
  end

  initial begin
    // Reset state
    idle(3);
    chk_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // 1: basic routing at unity gain, busy during the pass
    set_src(1000, -500, 2000, 300, UNITY_GAIN, UNITY_GAIN, UNITY_GAIN, UNITY_GAIN, 4'b1010);
    strobe(1, 3000, -200);
    chk("busy_in_pass", longint'(busy), 1);
    idle(9);
    chk("busy_after_pass", longint'(busy), 0);
    chk("clip_l_after_t1", longint'(clip_left), 0);

    // 2: positive saturation on both sides
    set_src(4194303, 4194303, 0, 0, 63, 63, 0, 0, 4'b1010);
    strobe(1, 8388607, 8388607);
    idle(9);
    chk("clip_left_sat", longint'(clip_left), CLIP_EN);
    chk("clip_right_sat", longint'(clip_right), CLIP_EN);
    pulse_clr();
    chk("clip_left_clr", longint'(clip_left), 0);

    // 2b: negative saturation on the left
    set_src(-4194304, 0, -4194304, 0, 63, 0, 63, 0, 4'b1010);
    strobe(1, -8388608, 0);
    idle(9);
    pulse_clr();

    // 3: second strobe while busy is dropped and flagged
    set_src(1000, -500, 2000, 300, 16, 16, 16, 16, 4'b1010);
    strobe(1, 3000, -200);
    idle(1);
    strobe(0, 0, 0);
    idle(9);
    chk("overrun_set", longint'(overrun), 1);
    pulse_clr();
    chk("overrun_clr", longint'(overrun), 0);
    strobe(1, 3000, -200);
    @(negedge clk);
    next_sample = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    overrun_clr = 1'b0;
    idle(8);
    chk("overrun_set_wins", longint'(overrun), 1);
    pulse_clr();

    // 4: inputs changed after capture do not affect the pass
    set_src(100, 200, 300, 400, 16, 16, 16, 16, 4'b0011);
    strobe(1, 700, 300);
    @(negedge clk);
    set_src(7777, 7777, 7777, 7777, 63, 63, 63, 63, 4'b1100);
    idle(9);

    // 5: reset mid-pass aborts it without out_valid
    set_src(5000, 5000, 5000, 5000, 16, 16, 16, 16, 4'b0000);
    strobe(0, 0, 0);
    idle(2);
    rst = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    idle(10);
    set_src(1000, -500, 2000, 300, 16, 16, 16, 16, 4'b1010);
    strobe(1, 3000, -200);
    idle(9);

    // 6: floor on negative product, full mute, empty side
    set_src(-3, 999, 999, 999, 8, 0, 0, 0, 4'b1110);
    strobe(1, -2, 0);
    idle(9);
    set_src(1234, -4321, 55555, -77, 0, 0, 0, 0, 4'b0101);
    strobe(1, 0, 0);
    idle(9);
    set_src(100, 200, 300, -50, 16, 16, 16, 16, 4'b0000);
    strobe(1, 550, 0);
    idle(9);

    chk("scoreboard_drained", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
